// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        OUT_LO = 3'd4,
        OUT_HI = 3'd5
    } state_t;

    localparam logic        OP_ADD     = 1'b1;
    localparam logic        OP_MUL     = 1'b0;
    localparam logic [15:0] ERR_RESULT = 16'hFFFF;

endpackage

// File: rtl/alu_op_sequencer_nibble_assembler.sv
// Nibble counter plus the two operand registers; nibbles arrive LS-first.
module nibble_assembler #(
    parameter int DATA_W  = 16,
    parameter int NIBBLES = DATA_W / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_first,
    input  logic              i_next,
    input  logic [3:0]        i_nib_a,
    input  logic [3:0]        i_nib_b,
    output logic [DATA_W-1:0] o_operand_a,
    output logic [DATA_W-1:0] o_operand_b,
    output logic              o_done
);

    localparam int CNT_W = $clog2(NIBBLES + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    // The first nibble also clears the stale upper bits of the previous operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (i_first) begin
            r_a   <= {{(DATA_W-4){1'b0}}, i_nib_a};
            r_b   <= {{(DATA_W-4){1'b0}}, i_nib_b};
            r_cnt <= CNT_W'(1);
        end else if (i_next) begin
            r_a[{r_cnt, 2'b00} +: 4] <= i_nib_a;
            r_b[{r_cnt, 2'b00} +: 4] <= i_nib_b;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done      = i_next && (r_cnt == CNT_W'(NIBBLES - 1));
    assign o_operand_a = r_a;
    assign o_operand_b = r_b;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one add/mul operation: nibble load, valid/ready issue,
// result wait with timeout, and a two-beat byte return.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NIBBLES = DATA_W / 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [3:0]        nib_a,
    input  logic [3:0]        nib_b,
    input  logic              op_sel,
    output logic              busy,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              op_code,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              out_valid,
    output logic [7:0]        out_byte,
    output logic              out_hi,
    output logic              out_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          r_state;
    logic [TO_W-1:0] r_tmo;
    logic [7:0]      r_res_hi;
    logic            r_busy;
    logic            r_op_valid;
    logic            r_op_code;
    logic            r_out_valid;
    logic [7:0]      r_out_byte;
    logic            r_out_hi;
    logic            r_out_err;

    logic w_first;
    logic w_next;
    logic w_done;

    assign w_first = (r_state == IDLE) && load_en;
    assign w_next  = (r_state == LOAD) && load_en;

    nibble_assembler #(
        .DATA_W  (DATA_W),
        .NIBBLES (NIBBLES)
    ) u_asm (
        .clk         (clock),
        .rst_n       (reset),
        .i_first     (w_first),
        .i_next      (w_next),
        .i_nib_a     (nib_a),
        .i_nib_b     (nib_b),
        .o_operand_a (operand_a),
        .o_operand_b (operand_b),
        .o_done      (w_done)
    );

    // Only the high byte needs to be kept; the low byte goes straight out on entry to OUT_LO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_tmo       <= '0;
            r_res_hi    <= '0;
            r_busy      <= 1'b0;
            r_op_valid  <= 1'b0;
            r_op_code   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_byte  <= '0;
            r_out_hi    <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_en) begin
                        r_op_code <= op_sel;
                        r_busy    <= 1'b1;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_done) begin
                        r_op_valid <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        r_op_valid <= 1'b0;
                        r_tmo      <= '0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (res_valid) begin
                        r_res_hi    <= res_data[15:8];
                        r_out_byte  <= res_data[7:0];
                        r_out_err   <= 1'b0;
                        r_out_hi    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT_LO;
                    end else if (r_tmo == TO_W'(TIMEOUT - 1)) begin
                        r_res_hi    <= ERR_RESULT[15:8];
                        r_out_byte  <= ERR_RESULT[7:0];
                        r_out_err   <= 1'b1;
                        r_out_hi    <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT_LO;
                    end else begin
                        r_tmo <= r_tmo + TO_W'(1);
                    end
                end
                OUT_LO: begin
                    r_out_byte <= r_res_hi;
                    r_out_hi   <= 1'b1;
                    r_state    <= OUT_HI;
                end
                OUT_HI: begin
                    r_out_valid <= 1'b0;
                    r_out_hi    <= 1'b0;
                    r_out_err   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign op_valid  = r_op_valid;
    assign op_code   = r_op_code;
    assign out_valid = r_out_valid;
    assign out_byte  = r_out_byte;
    assign out_hi    = r_out_hi;
    assign out_err   = r_out_err;

endmodule
